radio_multi: RTL and testbench

- Multi-channel RC receiver front end. Measures the high time of NUM_CH PWM lines from the transmitter receiver, sampled on the 1 MHz clock.
- Maps each accepted pulse onto a CMD_W-bit command and raises an update strobe for it.
- Rejects glitches and over-length pulses, and falls back to a failsafe value when a channel goes silent.
- Feeds the flight controller's command mixer. Everything runs synchronously on clk_1M; no logic is clocked by the radio inputs.

---
 rtl/radio_pkg.sv | 19 +
 rtl/radio_chan.sv | 80 ++++++++
 rtl/radio_multi.sv | 38 +++
 tb/tb_radio_multi.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/radio_pkg.sv
// radio_pkg: default timing constants and counter-width helpers for the RC receiver front end
package radio_pkg;
  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_CMD_W        = 10;
  localparam int DEF_MIN_US       = 987;
  localparam int DEF_MAX_US       = 2010;
  localparam int DEF_MIN_VALID_US = 500;
  localparam int DEF_MAX_VALID_US = 2500;
  localparam int DEF_TIMEOUT_US   = 25000;
  localparam int DEF_RST_VAL      = 512;

  function automatic int width_bits(input int max_valid_us);
    return $clog2(max_valid_us + 2);
  endfunction

  function automatic int timeout_bits(input int timeout_us);
    return $clog2(timeout_us + 1);
  endfunction
endpackage

// File: rtl/radio_chan.sv
// radio_chan: one PWM channel -- synchroniser, pulse-width measurement, acceptance/clamp and failsafe timeout
module radio_chan
  import radio_pkg::*;
#(
  parameter int CMD_W        = DEF_CMD_W,
  parameter int MIN_US       = DEF_MIN_US,
  parameter int MAX_US       = DEF_MAX_US,
  parameter int MIN_VALID_US = DEF_MIN_VALID_US,
  parameter int MAX_VALID_US = DEF_MAX_VALID_US,
  parameter int TIMEOUT_US   = DEF_TIMEOUT_US,
  parameter int RST_VAL      = DEF_RST_VAL
) (
  input  logic             clk_1M,
  input  logic             rst,
  input  logic             radio_i,
  output logic [CMD_W-1:0] cmd_o,
  output logic             update_o,
  output logic             valid_o
);
  localparam int WW = width_bits(MAX_VALID_US);
  localparam int TW = timeout_bits(TIMEOUT_US);
  localparam logic [WW-1:0] W_MIN = WW'(MIN_US);
  localparam logic [WW-1:0] W_MAX = WW'(MAX_US);
  localparam logic [WW-1:0] W_VMIN = WW'(MIN_VALID_US);
  localparam logic [WW-1:0] W_VMAX = WW'(MAX_VALID_US);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_US);
  localparam logic [CMD_W-1:0] CMD_RST = CMD_W'(RST_VAL);

  logic s1_q, s2_q, s3_q;
  logic meas_q, meas_d;
  logic [WW-1:0] width_q, width_d, diff;
  logic [TW-1:0] to_q, to_d;
  logic [CMD_W-1:0] cmd_q, cmd_d, clamp;
  logic upd_q, valid_q, valid_d;
  logic rise, fall, acc, expire;

  // edge detect, measurement, acceptance and timeout next-state
  always_comb begin
    rise = s2_q & ~s3_q;
    fall = ~s2_q & s3_q & meas_q;
    acc = fall && width_q >= W_VMIN && width_q <= W_VMAX;
    diff = width_q - W_MIN;
    clamp = width_q < W_MIN ? '0 : width_q > W_MAX ? '1 : diff[CMD_W-1:0];
    meas_d = rise | (meas_q & ~fall);
    width_d = rise ? WW'(1) : (meas_q && s2_q && width_q != '1) ? width_q + WW'(1) : width_q;
    to_d = acc ? '0 : to_q == TO_MAX ? to_q : to_q + TW'(1);
    expire = to_d == TO_MAX;
    cmd_d = acc ? clamp : expire ? CMD_RST : cmd_q;
    valid_d = acc | (valid_q & ~expire);
  end

  // state registers; synchroniser resets high so a line already high at release is not a rise
  always_ff @(posedge clk_1M) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
      meas_q <= 1'b0;
      width_q <= '0;
      to_q <= '0;
      cmd_q <= CMD_RST;
      upd_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s1_q <= radio_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
      meas_q <= meas_d;
      width_q <= width_d;
      to_q <= to_d;
      cmd_q <= cmd_d;
      upd_q <= acc;
      valid_q <= valid_d;
    end
  end

  assign cmd_o = cmd_q;
  assign update_o = upd_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/radio_multi.sv
// radio_multi: NUM_CH independent PWM receiver channels with a combined failsafe flag
module radio_multi
  import radio_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int CMD_W        = DEF_CMD_W,
  parameter int MIN_US       = DEF_MIN_US,
  parameter int MAX_US       = DEF_MAX_US,
  parameter int MIN_VALID_US = DEF_MIN_VALID_US,
  parameter int MAX_VALID_US = DEF_MAX_VALID_US,
  parameter int TIMEOUT_US   = DEF_TIMEOUT_US,
  parameter int RST_VAL      = DEF_RST_VAL
) (
  input  logic                    clk_1M,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       radio_in,
  output logic [NUM_CH*CMD_W-1:0] cmd_out,
  output logic [NUM_CH-1:0]       update_out,
  output logic [NUM_CH-1:0]       valid_out,
  output logic                    failsafe_out
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    radio_chan #(
      .CMD_W(CMD_W), .MIN_US(MIN_US), .MAX_US(MAX_US),
      .MIN_VALID_US(MIN_VALID_US), .MAX_VALID_US(MAX_VALID_US),
      .TIMEOUT_US(TIMEOUT_US), .RST_VAL(RST_VAL)
    ) u_chan (
      .clk_1M(clk_1M),
      .rst(rst),
      .radio_i(radio_in[i]),
      .cmd_o(cmd_out[i*CMD_W +: CMD_W]),
      .update_o(update_out[i]),
      .valid_o(valid_out[i])
    );
  end

  assign failsafe_out = |(~valid_out);
endmodule

// File: tb/tb_radio_multi.sv
// tb_radio_multi: directed pulses on each channel, checked every cycle against a pulse-level model plus literal expectations
`timescale 1ns/1ps
module tb_radio_multi;
  localparam int NCH = 4;
  localparam int CW = 10;
  localparam int TO = 25000;
  localparam int RV = 512;

  logic clk_1M = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] radio_in = '0;
  logic [NCH*CW-1:0] cmd_out;
  logic [NCH-1:0] update_out, valid_out;
  logic failsafe_out;
  int checks = 0;
  int errors = 0;

  radio_multi dut (
    .clk_1M(clk_1M),
    .rst(rst),
    .radio_in(radio_in),
    .cmd_out(cmd_out),
    .update_out(update_out),
    .valid_out(valid_out),
    .failsafe_out(failsafe_out)
  );

  always #5 clk_1M = ~clk_1M;

  task automatic chk(input string name, input logic [15:0] act, input int exp);
    checks++;
    if (act !== 16'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: a pulse is the run of clock edges that sample the line high after a
  // low sample; it is judged two edges after the first low sample. A channel
  // times out TO edges after its last acceptance (or reset).
  longint cyc = 0;
  bit started = 0;
  bit m_acc;
  int m_cmd[NCH];
  bit m_upd[NCH], m_valid[NCH], prev[NCH], armed[NCH];
  int n[NCH], pend_w[NCH];
  longint pend_at[NCH], last[NCH];

  function automatic int to_cmd(input int w);
    if (w < 987) return 0;
    if (w > 2010) return 1023;
    return w - 987;
  endfunction

  always @(posedge clk_1M) begin
    cyc++;
    started = 1;
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        m_cmd[c] = RV; m_upd[c] = 0; m_valid[c] = 0; last[c] = cyc;
        prev[c] = 1; armed[c] = 0; pend_at[c] = -1; n[c] = 0; pend_w[c] = 0;
      end else begin
        m_upd[c] = 0;
        m_acc = pend_at[c] == cyc && pend_w[c] >= 500 && pend_w[c] <= 2500;
        if (pend_at[c] == cyc) pend_at[c] = -1;
        if (m_acc) begin
          m_cmd[c] = to_cmd(pend_w[c]); m_upd[c] = 1; m_valid[c] = 1; last[c] = cyc;
        end else if (cyc - last[c] >= TO) begin
          m_valid[c] = 0; m_cmd[c] = RV;
        end
        if (radio_in[c] && !prev[c]) begin
          armed[c] = 1; n[c] = 1;
        end else if (radio_in[c] && armed[c]) begin
          n[c]++;
        end else if (!radio_in[c] && prev[c] && armed[c]) begin
          pend_at[c] = cyc + 2; pend_w[c] = n[c]; armed[c] = 0;
        end
        prev[c] = radio_in[c];
      end
    end
  end

  always @(negedge clk_1M) begin
    if (started) begin
      bit any_invalid;
      any_invalid = 0;
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("model cmd ch%0d cyc %0d", c, cyc), 16'(cmd_out[c*CW +: CW]), m_cmd[c]);
        chk($sformatf("model update ch%0d cyc %0d", c, cyc), 16'(update_out[c]), int'(m_upd[c]));
        chk($sformatf("model valid ch%0d cyc %0d", c, cyc), 16'(valid_out[c]), int'(m_valid[c]));
        if (!m_valid[c]) any_invalid = 1;
      end
      chk($sformatf("model failsafe cyc %0d", cyc), 16'(failsafe_out), int'(any_invalid));
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk_1M);
    #1;
  endtask

  task automatic pulse_chk(input int c, input int w, input int exp_cmd, input bit acc);
    radio_in[c] = 1'b1;
    tick(w);
    radio_in[c] = 1'b0;
    tick(2);
    chk($sformatf("ch%0d w%0d early strobe", c, w), 16'(update_out[c]), 0);
    tick(1);
    chk($sformatf("ch%0d w%0d strobe", c, w), 16'(update_out[c]), int'(acc));
    chk($sformatf("ch%0d w%0d cmd", c, w), 16'(cmd_out[c*CW +: CW]), exp_cmd);
    tick(1);
    chk($sformatf("ch%0d w%0d strobe width", c, w), 16'(update_out[c]), 0);
    tick(20);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(100);
    for (int c = 0; c < NCH; c++) chk($sformatf("idle cmd ch%0d", c), 16'(cmd_out[c*CW +: CW]), RV);
    chk("idle valid", 16'(valid_out), 0);
    chk("idle update", 16'(update_out), 0);
    chk("idle failsafe", 16'(failsafe_out), 1);

    pulse_chk(0, 1500, 513, 1);
    chk("ch0 valid", 16'(valid_out), 1);
    for (int c = 1; c < NCH; c++) chk($sformatf("ch%0d untouched", c), 16'(cmd_out[c*CW +: CW]), RV);

    pulse_chk(1, 900, 0, 1);
    pulse_chk(1, 987, 0, 1);
    pulse_chk(1, 2010, 1023, 1);
    pulse_chk(1, 2100, 1023, 1);
    pulse_chk(1, 499, 1023, 0);
    pulse_chk(1, 500, 0, 1);
    pulse_chk(1, 988, 1, 1);
    pulse_chk(1, 2009, 1022, 1);
    pulse_chk(1, 2500, 1023, 1);
    pulse_chk(1, 2501, 1023, 0);

    pulse_chk(2, 300, RV, 0);
    pulse_chk(2, 2600, RV, 0);
    for (int k = 0; k < 3; k++) pulse_chk(2, 1, RV, 0);
    chk("ch2 still invalid", 16'(valid_out[2]), 0);

    radio_in[3] = 1'b1;
    tick(1200);
    radio_in[3] = 1'b0;
    tick(3);
    chk("ch3 accept cmd", 16'(cmd_out[3*CW +: CW]), 213);
    chk("ch3 accept valid", 16'(valid_out[3]), 1);
    tick(TO - 1);
    chk("ch3 pre-timeout valid", 16'(valid_out[3]), 1);
    chk("ch3 pre-timeout cmd", 16'(cmd_out[3*CW +: CW]), 213);
    tick(1);
    chk("ch3 timeout valid", 16'(valid_out[3]), 0);
    chk("ch3 timeout cmd", 16'(cmd_out[3*CW +: CW]), RV);
    chk("ch3 timeout failsafe", 16'(failsafe_out), 1);
    pulse_chk(3, 1800, 813, 1);
    chk("ch3 revalid", 16'(valid_out[3]), 1);

    radio_in[0] = 1'b1;
    tick(700);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid-pulse reset cmd", 16'(cmd_out[CW-1:0]), RV);
    chk("mid-pulse reset valid", 16'(valid_out), 0);
    tick(300);
    radio_in[0] = 1'b0;
    tick(5);
    chk("discarded pulse update", 16'(update_out), 0);
    chk("discarded pulse cmd", 16'(cmd_out[CW-1:0]), RV);
    tick(20);

    radio_in[1:0] = 2'b11;
    tick(1100);
    radio_in[1:0] = 2'b00;
    tick(3);
    chk("simultaneous strobes", 16'(update_out), 3);
    chk("simultaneous cmd ch0", 16'(cmd_out[0 +: CW]), 113);
    chk("simultaneous cmd ch1", 16'(cmd_out[CW +: CW]), 113);
    tick(1);
    chk("simultaneous strobe end", 16'(update_out), 0);
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
